txbuf_drain: RTL and testbench

TXBUF_DRAIN -- requirements
Module: txbuf_drain

---
 rtl/txbuf_drain_pkg.sv | 29 ++
 rtl/txbuf_drain_ram.sv | 27 ++
 rtl/txbuf_drain.sv | 208 ++++++++++++++++++++
 tb/tb_txbuf_drain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/txbuf_drain_pkg.sv
// Constants and state encoding shared by the loopback transmit buffer.
package txbuf_drain_pkg;

    localparam int DEPTH_BYTES_DEFAULT = 1280;
    localparam int WRN_CYCLES_DEFAULT  = 6000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FILL       = 3'd1,
        DRAIN_RD   = 3'd2,
        DRAIN_WAIT = 3'd3,
        DRAIN_WR   = 3'd4,
        DRAIN_ACK  = 3'd5
    } drain_state_t;

    // Pointers must hold the value DEPTH itself, so they need one more code than the RAM address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/txbuf_drain_ram.sv
// Byte buffer with a single write port and a registered read port.
// Written so that synthesis infers block RAM.
module txbuf_ram #(
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/txbuf_drain.sv
// Loopback transmit buffer: packs incoming bits into bytes, then drains the
// buffer to txmit one byte per wrn strobe, paced by txmit's tbre.
//
// state      | meaning
// IDLE       | buffer empty, waiting for the first bit
// FILL       | packing bits LSB-first and writing whole bytes
// DRAIN_RD   | read issued at rd_ptr
// DRAIN_WAIT | byte lands in tdin; waiting for tbre high
// DRAIN_WR   | wrn held low for WRN_CYCLES cycles
// DRAIN_ACK  | waiting for tbre low, then next byte or done
module txbuf_drain
    import txbuf_drain_pkg::*;
#(
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
    parameter int WRN_CYCLES  = WRN_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       flush,
    input  logic       tbre,
    output logic [7:0] tdin,
    output logic       wrn,
    output logic       filling,
    output logic       draining,
    output logic       done,
    output logic       overflow
);

    localparam int PW = ptr_width(DEPTH_BYTES);
    localparam int AW = addr_width(DEPTH_BYTES);
    localparam int TW = timer_width(WRN_CYCLES);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH_BYTES - 1);
    localparam logic [TW-1:0] WRN_LOAD  = TW'(WRN_CYCLES - 1);

    drain_state_t  state, state_next;
    logic [PW-1:0] wr_ptr, wr_ptr_next;
    logic [PW-1:0] rd_ptr, rd_ptr_next;
    logic [7:0]    shreg, shreg_next, shreg_upd;
    logic [7:0]    wr_byte, ram_q;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic          ram_we, ram_re, rd_pending;
    logic          done_next, overflow_next;
    logic          tbre_meta, tbre_s;
    logic          in_drain, in_drain_next;

    assign in_drain      = state inside {DRAIN_RD, DRAIN_WAIT, DRAIN_WR, DRAIN_ACK};
    assign in_drain_next = state_next inside {DRAIN_RD, DRAIN_WAIT, DRAIN_WR, DRAIN_ACK};

    // tbre comes from the clk16x domain; only tbre_s is used past this point.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tbre_meta <= 1'b0;
            tbre_s    <= 1'b0;
        end else begin
            tbre_meta <= tbre;
            tbre_s    <= tbre_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        timer_next    = timer;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        done_next     = 1'b0;
        overflow_next = overflow;

        // The shift register is cleared after every write, so unfilled bits read as zero padding.
        shreg_upd = shreg;
        if (bit_valid) begin
            shreg_upd[bit_cnt] = bit_in;
        end
        wr_byte = shreg_upd;

        if (bit_valid && in_drain) begin
            overflow_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bit_valid) begin
                    shreg_next   = shreg_upd;
                    bit_cnt_next = bit_cnt + 3'd1;
                    state_next   = FILL;
                end
            end
            FILL: begin
                if (bit_valid && bit_cnt == 3'd7) begin
                    ram_we       = 1'b1;
                    shreg_next   = '0;
                    bit_cnt_next = '0;
                    wr_ptr_next  = wr_ptr + PW'(1);
                    if (flush || wr_ptr == LAST_SLOT) begin
                        state_next = DRAIN_RD;
                    end
                end else if (flush) begin
                    if (bit_valid || bit_cnt != 3'd0) begin
                        ram_we       = 1'b1;
                        shreg_next   = '0;
                        bit_cnt_next = '0;
                        wr_ptr_next  = wr_ptr + PW'(1);
                    end
                    if (bit_valid || bit_cnt != 3'd0 || wr_ptr != '0) begin
                        state_next = DRAIN_RD;
                    end
                end else if (bit_valid) begin
                    shreg_next   = shreg_upd;
                    bit_cnt_next = bit_cnt + 3'd1;
                end
            end
            DRAIN_RD: begin
                ram_re     = 1'b1;
                state_next = DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
                if (tbre_s) begin
                    timer_next = WRN_LOAD;
                    state_next = DRAIN_WR;
                end
            end
            DRAIN_WR: begin
                if (timer == '0) begin
                    state_next = DRAIN_ACK;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            DRAIN_ACK: begin
                if (!tbre_s) begin
                    if ((rd_ptr + PW'(1)) == wr_ptr) begin
                        done_next   = 1'b1;
                        rd_ptr_next = '0;
                        wr_ptr_next = '0;
                        state_next  = IDLE;
                    end else begin
                        rd_ptr_next = rd_ptr + PW'(1);
                        state_next  = DRAIN_RD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            rd_pending <= 1'b0;
            tdin       <= '0;
            wrn        <= 1'b1;
            filling    <= 1'b0;
            draining   <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            timer      <= timer_next;
            rd_pending <= (state == DRAIN_RD);
            if (rd_pending) begin
                tdin <= ram_q;
            end
            wrn        <= (state_next != DRAIN_WR);
            filling    <= (state_next == FILL);
            draining   <= in_drain_next;
            done       <= done_next;
            overflow   <= overflow_next;
        end
    end

    txbuf_ram #(
        .DEPTH (DEPTH_BYTES),
        .AW    (AW)
    ) u_ram (
        .clk     (CLK),
        .we      (ram_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_byte),
        .re      (ram_re),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_txbuf_drain.sv
// Bench for txbuf_drain: random bit streams checked against a byte-list model
// and a simple txmit model that captures tdin on each wrn rising edge.
module tb_txbuf_drain;

    localparam int DEPTH = 4;
    localparam int WRN   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in, bit_valid, flush, tbre;
    logic [7:0] tdin;
    logic       wrn, filling, draining, done, overflow;

    always #5 clk = ~clk;

    txbuf_drain #(
        .DEPTH_BYTES (DEPTH),
        .WRN_CYCLES  (WRN)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .flush     (flush),
        .tbre      (tbre),
        .tdin      (tdin),
        .wrn       (wrn),
        .filling   (filling),
        .draining  (draining),
        .done      (done),
        .overflow  (overflow)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    int         done_cnt;
    logic       wrn_prev;
    int         low_len;
    logic [7:0] held;
    int         busy;
    bit         tbre_hold;
    bit         model_skip;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; then the txmit model reacts to what the DUT shows.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (model_skip) begin
            wrn_prev = wrn;
            busy     = 0;
        end else begin
            if (!wrn) begin
                if (wrn_prev) begin
                    low_len = 1;
                    held    = tdin;
                    check("draining_in_wr", int'(draining), 1);
                end else begin
                    low_len++;
                    check("tdin_stable", int'(tdin), int'(held));
                end
            end else if (!wrn_prev) begin
                check("wrn_width", low_len, WRN);
                if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
                else e = 9'h100;
                check("byte", int'(held), int'(e));
                busy = int'($urandom_range(3, 8));
            end else if (busy > 0) begin
                busy--;
            end
            wrn_prev = wrn;
        end
        tbre = (tbre_hold || busy > 0) ? 1'b0 : 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bit_valid  = 1'b0;
        flush      = 1'b0;
        model_skip = 1'b1;
        tick();
        tick();
        rst        = 1'b0;
        model_skip = 1'b0;
        exp_q.delete();
        exp_ovf    = 1'b0;
    endtask

    // mode 0: no flush (n must be DEPTH*8), 1: flush with last bit, 2: flush afterwards
    task automatic run_fill(input int n, input int mode, input logic [31:0] pat);
        logic [7:0] b;
        int nbytes;
        nbytes = (n + 7) / 8;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (i * 8 + j < n) b[j] = pat[i*8+j];
            end
            exp_q.push_back(b);
        end
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            bit_valid = 1'b1;
            bit_in    = pat[k];
            flush     = (mode == 1 && k == n - 1);
            tick();
            bit_valid = 1'b0;
            flush     = 1'b0;
            if (k < n - 1) check("filling", int'(filling), 1);
        end
        if (mode == 2) begin
            repeat ($urandom_range(0, 2)) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        check("fill_end_filling", int'(filling), 0);
        check("fill_end_draining", int'(draining), 1);
    endtask

    task automatic run_drain(input bit inject);
        bit seen;
        bit injected;
        int d0;
        seen     = 1'b0;
        injected = 1'b0;
        d0       = done_cnt;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (inject && !injected && !wrn) begin
                bit_valid = 1'b1;
                bit_in    = 1'($urandom_range(0, 1));
                injected  = 1'b1;
                exp_ovf   = 1'b1;
            end
            tick();
            bit_valid = 1'b0;
            if (done) begin
                seen = 1'b1;
                check("done_idle_draining", int'(draining), 0);
                check("done_idle_filling", int'(filling), 0);
                check("done_idle_wrn", int'(wrn), 1);
                check("drained_all", exp_q.size(), 0);
            end
        end
        check("done_seen", int'(seen), 1);
        repeat (3) tick();
        check("done_once", done_cnt - d0, 1);
        check("overflow", int'(overflow), int'(exp_ovf));
    endtask

    initial begin
        bit any_low;
        bit found;
        int n, mode;
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; tbre = 1'b1;
        tbre_hold = 1'b0; model_skip = 1'b0; wrn_prev = 1'b1; busy = 0;
        low_len = 0; held = 8'h00; done_cnt = 0; exp_ovf = 1'b0;

        do_reset();
        check("rst_tdin", int'(tdin), 0);
        check("rst_wrn", int'(wrn), 1);
        check("rst_filling", int'(filling), 0);
        check("rst_draining", int'(draining), 0);
        check("rst_done", int'(done), 0);
        check("rst_overflow", int'(overflow), 0);

        // full buffer of A5,3C,FF,00
        run_fill(32, 0, 32'h00FF3CA5);
        run_drain(1'b0);

        // 11 bits then flush: second byte zero-padded
        run_fill(11, 2, $urandom);
        run_drain(1'b0);

        // dropped bit while draining
        run_fill(24, 2, $urandom);
        run_drain(1'b1);

        // txmit never empty: must sit with wrn high
        tbre_hold = 1'b1;
        run_fill(8, 2, $urandom);
        any_low = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!wrn) any_low = 1'b1;
        end
        check("hold_wrn_high", int'(any_low), 0);
        check("hold_draining", int'(draining), 1);
        tbre_hold = 1'b0;
        run_drain(1'b0);

        // reset in the middle of a write strobe
        run_fill(16, 2, $urandom);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            tick();
            if (!wrn) found = 1'b1;
        end
        check("rst_found_wr", int'(found), 1);
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        check("pre_rst_overflow", int'(overflow), 1);
        rst = 1'b1;
        model_skip = 1'b1;
        tick();
        rst = 1'b0;
        model_skip = 1'b0;
        check("mid_rst_wrn", int'(wrn), 1);
        check("mid_rst_filling", int'(filling), 0);
        check("mid_rst_draining", int'(draining), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_tdin", int'(tdin), 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", int'(draining), 0);
        run_fill(32, 0, $urandom);
        run_drain(1'b0);

        // flush in IDLE is ignored; flush with the 8th bit gives one byte, no pad byte
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        check("idle_flush_filling", int'(filling), 0);
        check("idle_flush_draining", int'(draining), 0);
        check("idle_flush_wrn", int'(wrn), 1);
        run_fill(8, 1, $urandom);
        run_drain(1'b0);

        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(1, 32));
            if (n == 32) mode = int'($urandom_range(0, 1));
            else if (n == 1) mode = 2;
            else mode = int'($urandom_range(1, 2));
            run_fill(n, mode, $urandom);
            run_drain(($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
